// File: rtl/clock_lock_reset_seq.sv
// rtl/clock_lock_reset_seq.sv - MMCM lock sequencer: staged reset release, lock-timeout retry, lock event reporting
// Define CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN to add the lossCount output (saturating count of RUN exits).
module clock_lock_reset_seq #(
  parameter int HOLD_CYCLES    = 64,
  parameter int STAGE_GAP      = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        locked,
  output logic        pllRst,
  output logic        nRstCore,
  output logic        nRstPeriph,
  output logic        ready,
  output logic        enq__ENA,
  output logic [15:0] enq_v,
  input  logic        enq__RDY
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
  ,
  output logic [15:0] lossCount
`endif
);

  localparam int MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_B = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] PRC_END  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP);

  localparam logic [3:0]  CODE_NONE     = 4'd0;
  localparam logic [3:0]  CODE_ACQUIRED = 4'd1;
  localparam logic [3:0]  CODE_LOST     = 4'd2;
  localparam logic [3:0]  CODE_TIMEOUT  = 4'd3;
  localparam logic [10:0] RETRY_MAX     = 11'h7FF;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    HOLD,
    REL_CORE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          locked_s;
  logic [10:0]   retry;
  logic [10:0]   retry_post;
  logic [3:0]    post_code;

  // locked comes straight from the MMCM and is asynchronous to CLK
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // Event to post on this edge; mirrors the transition conditions of the FSM below
  always_comb begin
    post_code = CODE_NONE;
    case (state)
      WAIT_LOCK: if (!locked_s && cnt == TO_END) post_code = CODE_TIMEOUT;
      REL_CORE:  if (locked_s && cnt == GAP_END) post_code = CODE_ACQUIRED;
      RUN:       if (!locked_s) post_code = CODE_LOST;
      default:   post_code = CODE_NONE;
    endcase
  end

  always_comb begin
    retry_post = retry;
    if (post_code == CODE_TIMEOUT && retry != RETRY_MAX) retry_post = retry + 11'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= PLL_RST;
      cnt        <= CNT_ZERO;
      pllRst     <= 1'b1;
      nRstCore   <= 1'b0;
      nRstPeriph <= 1'b0;
      ready      <= 1'b0;
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
      lossCount  <= 16'd0;
`endif
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == PRC_END) begin
            state  <= WAIT_LOCK;
            cnt    <= CNT_ZERO;
            pllRst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= HOLD;
            cnt   <= CNT_ONE;
          end else if (cnt == TO_END) begin
            state  <= PLL_RST;
            cnt    <= CNT_ZERO;
            pllRst <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= CNT_ZERO;
          end else if (cnt == HOLD_END) begin
            state    <= REL_CORE;
            cnt      <= CNT_ONE;
            nRstCore <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REL_CORE: begin
          if (!locked_s) begin
            state    <= WAIT_LOCK;
            cnt      <= CNT_ZERO;
            nRstCore <= 1'b0;
          end else if (cnt == GAP_END) begin
            state      <= RUN;
            cnt        <= CNT_ZERO;
            nRstPeriph <= 1'b1;
            ready      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state      <= WAIT_LOCK;
            cnt        <= CNT_ZERO;
            nRstCore   <= 1'b0;
            nRstPeriph <= 1'b0;
            ready      <= 1'b0;
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
            if (lossCount != 16'hFFFF) lossCount <= lossCount + 16'd1;
`endif
          end
        end
        default: begin
          state  <= PLL_RST;
          cnt    <= CNT_ZERO;
          pllRst <= 1'b1;
        end
      endcase
    end
  end

  // One-entry event buffer: a new event always wins, overflow flags an unread overwrite
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      enq__ENA <= 1'b0;
      enq_v    <= 16'd0;
      retry    <= 11'd0;
    end else begin
      retry <= retry_post;
      if (post_code != CODE_NONE) begin
        enq__ENA <= 1'b1;
        enq_v    <= {post_code, enq__ENA && !enq__RDY, retry_post};
      end else if (enq__ENA && enq__RDY) begin
        enq__ENA <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_lock_reset_seq.sv
// tb/tb_clock_lock_reset_seq.sv - bench for clock_lock_reset_seq: directed plan scenarios plus randomized lock traffic
`timescale 1ns/1ps
module tb_clock_lock_reset_seq;
  localparam int HOLD = 4, GAP = 2, TMO = 20, PRC = 3;
  localparam int PH_RST = 0, PH_WAIT = 1, PH_HOLD = 2, PH_CORE = 3, PH_RUN = 4;

  logic clk = 1'b0, n_rst = 1'b0, lk = 1'b0, rdy = 1'b1;
  logic pll_rst, core_n, periph_n, ready, ena;
  logic [15:0] v;
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif
  int total = 0, bad = 0;

  int m_phase, m_age, m_retry, m_loss;
  bit m_q1, m_ls, m_pend;
  logic [15:0] m_word;

  clock_lock_reset_seq #(.HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .LOCK_TIMEOUT(TMO), .PLL_RST_CYCLES(PRC)) dut (
    .CLK(clk), .nRST(n_rst), .locked(lk), .pllRst(pll_rst), .nRstCore(core_n), .nRstPeriph(periph_n),
    .ready(ready), .enq__ENA(ena), .enq_v(v), .enq__RDY(rdy)
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
    , .lossCount(loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_phase = PH_RST; m_age = 0; m_retry = 0; m_loss = 0;
    m_q1 = 0; m_ls = 0; m_pend = 0; m_word = 16'd0;
  endtask

  // Phase/age view of the sequencer: outputs are pure functions of the phase
  task automatic model_edge(input bit pin, input bit rd);
    bit ls, acc;
    int ev;
    ls = m_ls; m_ls = m_q1; m_q1 = pin;
    acc = m_pend && rd;
    ev = 0;
    case (m_phase)
      PH_RST: begin m_age++; if (m_age >= PRC) begin m_phase = PH_WAIT; m_age = 0; end end
      PH_WAIT: if (ls) begin m_phase = PH_HOLD; m_age = 1; end
               else begin
                 m_age++;
                 if (m_age >= TMO) begin m_phase = PH_RST; m_age = 0; if (m_retry < 2047) m_retry++; ev = 3; end
               end
      PH_HOLD: if (!ls) begin m_phase = PH_WAIT; m_age = 0; end
               else if (m_age >= HOLD) begin m_phase = PH_CORE; m_age = 0; end
               else m_age++;
      PH_CORE: if (!ls) begin m_phase = PH_WAIT; m_age = 0; end
               else begin m_age++; if (m_age >= GAP) begin m_phase = PH_RUN; ev = 1; end end
      default: if (!ls) begin m_phase = PH_WAIT; m_age = 0; ev = 2; if (m_loss < 65535) m_loss++; end
    endcase
    if (ev != 0) begin
      m_word = {4'(ev), (m_pend && !acc), 11'(m_retry)};
      m_pend = 1;
    end else if (acc) begin
      m_pend = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (n_rst) model_edge(lk, rdy); else model_reset();
      #1;
    end
  endtask

  task automatic do_reset(input logic l, input logic r);
    @(posedge clk); #1;
    n_rst = 1'b0; lk = l; rdy = r; model_reset();
    step(3);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_rst = 1'b0; lk = 1'b1; rdy = 1'b1; model_reset();
    step(2);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pllRst got=%b exp=1", pll_rst); end
    total++; if (core_n !== 1'b0) begin bad++; $display("FAIL reset_nRstCore got=%b exp=0", core_n); end
    total++; if (periph_n !== 1'b0) begin bad++; $display("FAIL reset_nRstPeriph got=%b exp=0", periph_n); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (ena !== 1'b0) begin bad++; $display("FAIL reset_ena got=%b exp=0", ena); end
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_v got=%h exp=0000", v); end
  endtask

  task automatic test_acquire();
    int pll_fall, core_rise, periph_rise, ready_rise, ev_n;
    logic [15:0] ev_w;
    pll_fall = -1; core_rise = -1; periph_rise = -1; ready_rise = -1; ev_n = 0; ev_w = 16'd0;
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      step(1);
      if (pll_fall < 0 && pll_rst === 1'b0) pll_fall = e;
      if (core_rise < 0 && core_n === 1'b1) core_rise = e;
      if (periph_rise < 0 && periph_n === 1'b1) periph_rise = e;
      if (ready_rise < 0 && ready === 1'b1) ready_rise = e;
      if (ena === 1'b1) begin ev_n++; ev_w = v; end
    end
    total++; if (pll_fall != 3) begin bad++; $display("FAIL acq_pll_fall got=%0d exp=3", pll_fall); end
    total++; if (core_rise != 8) begin bad++; $display("FAIL acq_core_rise got=%0d exp=8", core_rise); end
    total++; if (periph_rise != 10) begin bad++; $display("FAIL acq_periph_rise got=%0d exp=10", periph_rise); end
    total++; if (ready_rise != 10) begin bad++; $display("FAIL acq_ready_rise got=%0d exp=10", ready_rise); end
    total++; if (ev_n != 1) begin bad++; $display("FAIL acq_event_cycles got=%0d exp=1", ev_n); end
    total++; if (ev_w !== 16'h1000) begin bad++; $display("FAIL acq_event_word got=%h exp=1000", ev_w); end
  endtask

  task automatic test_timeout();
    int ev_n, rise1, fall2;
    int ev_e[2];
    logic [15:0] ev_w[2];
    bit prev;
    ev_n = 0; rise1 = -1; fall2 = -1; ev_e[0] = -1; ev_e[1] = -1; ev_w[0] = 16'd0; ev_w[1] = 16'd0;
    do_reset(1'b0, 1'b1);
    prev = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      step(1);
      if (ena === 1'b1) begin if (ev_n < 2) begin ev_e[ev_n] = e; ev_w[ev_n] = v; end ev_n++; end
      if (!prev && pll_rst === 1'b1 && rise1 < 0) rise1 = e;
      if (prev && pll_rst === 1'b0 && rise1 >= 0 && fall2 < 0) fall2 = e;
      prev = pll_rst;
    end
    total++; if (ev_n != 2) begin bad++; $display("FAIL tmo_event_count got=%0d exp=2", ev_n); end
    total++; if (ev_e[0] != 23) begin bad++; $display("FAIL tmo_first_edge got=%0d exp=23", ev_e[0]); end
    total++; if (ev_w[0] !== 16'h3001) begin bad++; $display("FAIL tmo_first_word got=%h exp=3001", ev_w[0]); end
    total++; if (ev_e[1] != 46) begin bad++; $display("FAIL tmo_second_edge got=%0d exp=46", ev_e[1]); end
    total++; if (ev_w[1] !== 16'h3002) begin bad++; $display("FAIL tmo_second_word got=%h exp=3002", ev_w[1]); end
    total++; if (rise1 != 23) begin bad++; $display("FAIL tmo_pll_rise got=%0d exp=23", rise1); end
    total++; if (fall2 != 26) begin bad++; $display("FAIL tmo_pll_pulse_end got=%0d exp=26", fall2); end
  endtask

  task automatic test_loss();
    int cf, pf, rf, cr, pr, ev_n;
    int ev_e[2];
    logic [15:0] ev_w[2];
    cf = -1; pf = -1; rf = -1; cr = -1; pr = -1; ev_n = 0;
    ev_e[0] = -1; ev_e[1] = -1; ev_w[0] = 16'd0; ev_w[1] = 16'd0;
    do_reset(1'b1, 1'b1);
    step(12);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL loss_pre_ready got=%b exp=1", ready); end
    lk = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 6) lk = 1'b1;
      step(1);
      if (cf < 0 && core_n === 1'b0) cf = e;
      if (pf < 0 && periph_n === 1'b0) pf = e;
      if (rf < 0 && ready === 1'b0) rf = e;
      if (cf >= 0 && cr < 0 && core_n === 1'b1) cr = e;
      if (pf >= 0 && pr < 0 && periph_n === 1'b1) pr = e;
      if (ena === 1'b1) begin if (ev_n < 2) begin ev_e[ev_n] = e; ev_w[ev_n] = v; end ev_n++; end
    end
    total++; if (cf != 3) begin bad++; $display("FAIL loss_core_fall got=%0d exp=3", cf); end
    total++; if (pf != 3) begin bad++; $display("FAIL loss_periph_fall got=%0d exp=3", pf); end
    total++; if (rf != 3) begin bad++; $display("FAIL loss_ready_fall got=%0d exp=3", rf); end
    total++; if (ev_e[0] != 3) begin bad++; $display("FAIL loss_event_edge got=%0d exp=3", ev_e[0]); end
    total++; if (ev_w[0] !== 16'h2000) begin bad++; $display("FAIL loss_event_word got=%h exp=2000", ev_w[0]); end
    total++; if (cr != 12) begin bad++; $display("FAIL loss_core_rerise got=%0d exp=12", cr); end
    total++; if (pr != 14) begin bad++; $display("FAIL loss_periph_rerise got=%0d exp=14", pr); end
    total++; if (ev_n != 2) begin bad++; $display("FAIL loss_event_count got=%0d exp=2", ev_n); end
    total++; if (ev_w[1] !== 16'h1000) begin bad++; $display("FAIL loss_reacq_word got=%h exp=1000", ev_w[1]); end
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
    total++; if (loss_cnt !== 16'd1) begin bad++; $display("FAIL loss_count got=%0d exp=1", loss_cnt); end
`endif
  endtask

  task automatic test_hold_glitch();
    int cr, pr, ev_n, ev_e;
    logic [15:0] ev_w;
    cr = -1; pr = -1; ev_n = 0; ev_e = -1; ev_w = 16'd0;
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) lk = 1'b0;
      if (e == 6) lk = 1'b1;
      step(1);
      if (cr < 0 && core_n === 1'b1) cr = e;
      if (pr < 0 && periph_n === 1'b1) pr = e;
      if (ena === 1'b1) begin if (ev_e < 0) begin ev_e = e; ev_w = v; end ev_n++; end
    end
    total++; if (cr != 12) begin bad++; $display("FAIL glitch_core_rise got=%0d exp=12", cr); end
    total++; if (pr != 14) begin bad++; $display("FAIL glitch_periph_rise got=%0d exp=14", pr); end
    total++; if (ev_n != 1) begin bad++; $display("FAIL glitch_event_count got=%0d exp=1", ev_n); end
    total++; if (ev_e != 14) begin bad++; $display("FAIL glitch_event_edge got=%0d exp=14", ev_e); end
    total++; if (ev_w !== 16'h1000) begin bad++; $display("FAIL glitch_event_word got=%h exp=1000", ev_w); end
  endtask

  task automatic test_overflow();
    do_reset(1'b0, 1'b0);
    step(23);
    total++; if (ena !== 1'b1) begin bad++; $display("FAIL ovf_tmo_ena got=%b exp=1", ena); end
    total++; if (v !== 16'h3001) begin bad++; $display("FAIL ovf_tmo_word got=%h exp=3001", v); end
    step(1);
    lk = 1'b1;
    step(9);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ovf_ready got=%b exp=1", ready); end
    total++; if (v !== 16'h1801) begin bad++; $display("FAIL ovf_word got=%h exp=1801", v); end
    step(2);
    total++; if (ena !== 1'b1) begin bad++; $display("FAIL ovf_hold_ena got=%b exp=1", ena); end
    total++; if (v !== 16'h1801) begin bad++; $display("FAIL ovf_hold_word got=%h exp=1801", v); end
    rdy = 1'b1;
    step(1);
    total++; if (ena !== 1'b0) begin bad++; $display("FAIL ovf_accept_ena got=%b exp=0", ena); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b1);
    step(12);
    lk = 1'b0; rdy = 1'b0;
    step(5);
    lk = 1'b1;
    step(10);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ares_pre_ready got=%b exp=1", ready); end
    total++; if (v !== 16'h1800) begin bad++; $display("FAIL ares_pre_word got=%h exp=1800", v); end
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
    total++; if (loss_cnt !== 16'd1) begin bad++; $display("FAIL ares_pre_loss got=%0d exp=1", loss_cnt); end
`endif
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL ares_pllRst got=%b exp=1", pll_rst); end
    total++; if (core_n !== 1'b0) begin bad++; $display("FAIL ares_nRstCore got=%b exp=0", core_n); end
    total++; if (periph_n !== 1'b0) begin bad++; $display("FAIL ares_nRstPeriph got=%b exp=0", periph_n); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ares_ready got=%b exp=0", ready); end
    total++; if (ena !== 1'b0) begin bad++; $display("FAIL ares_ena got=%b exp=0", ena); end
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL ares_word got=%h exp=0000", v); end
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
    total++; if (loss_cnt !== 16'd0) begin bad++; $display("FAIL ares_loss got=%0d exp=0", loss_cnt); end
`endif
  endtask

  task automatic test_random();
    int run_left, start_bad;
    bit e_pll, e_core, e_run;
    start_bad = bad;
    for (int seg = 0; seg < 3; seg++) begin
      do_reset(1'($urandom_range(0, 1)), 1'b1);
      run_left = $urandom_range(1, 40);
      for (int c = 0; c < 400; c++) begin
        step(1);
        e_pll = (m_phase == PH_RST);
        e_core = (m_phase == PH_CORE) || (m_phase == PH_RUN);
        e_run = (m_phase == PH_RUN);
        total++; if (pll_rst !== e_pll) begin bad++; $display("FAIL rnd_pllRst c=%0d got=%b exp=%b", c, pll_rst, e_pll); end
        total++; if (core_n !== e_core) begin bad++; $display("FAIL rnd_nRstCore c=%0d got=%b exp=%b", c, core_n, e_core); end
        total++; if (periph_n !== e_run) begin bad++; $display("FAIL rnd_nRstPeriph c=%0d got=%b exp=%b", c, periph_n, e_run); end
        total++; if (ready !== e_run) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready, e_run); end
        total++; if (ena !== m_pend) begin bad++; $display("FAIL rnd_ena c=%0d got=%b exp=%b", c, ena, m_pend); end
        if (m_pend) begin
          total++; if (v !== m_word) begin bad++; $display("FAIL rnd_word c=%0d got=%h exp=%h", c, v, m_word); end
        end
`ifdef CLOCK_LOCK_RESET_SEQ_LOSS_CNT_EN
        total++; if (loss_cnt !== 16'(m_loss)) begin bad++; $display("FAIL rnd_loss c=%0d got=%0d exp=%0d", c, loss_cnt, m_loss); end
`endif
        run_left--;
        if (run_left <= 0) begin
          lk = ~lk;
          run_left = lk ? $urandom_range(1, 70) : $urandom_range(1, 45);
        end
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (bad - start_bad > 20) break;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_timeout();
    test_loss();
    test_hold_glitch();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
